// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
//   - Standard control/data widths for each inter-stage register (IF/ID .. MEM/WB).
//   - Bit positions of the individual signals inside the ID/EX control bundle.
package pipe_pkg;

  // IF/ID carries pc4 and the fetched instruction; it has no control bundle.
  localparam int unsigned IF_ID_DATA_W  = 64;
  // ID/EX data: pc4 (32) + operand a (32) + operand b or immediate (32) + dest reg (5).
  localparam int unsigned ID_EX_CTRL_W  = 8;
  localparam int unsigned ID_EX_DATA_W  = 101;
  // EX/MEM data: alu result (32) + store data (32) + dest reg (5).
  localparam int unsigned EX_MEM_CTRL_W = 3;
  localparam int unsigned EX_MEM_DATA_W = 69;
  // MEM/WB data: alu result or load data (32 + 32) + dest reg (5).
  localparam int unsigned MEM_WB_CTRL_W = 2;
  localparam int unsigned MEM_WB_DATA_W = 69;

  // ID/EX control bundle layout. aluc occupies bits [7:6].
  localparam int unsigned CTRL_WREG     = 0;
  localparam int unsigned CTRL_M2REG    = 1;
  localparam int unsigned CTRL_WMEM     = 2;
  localparam int unsigned CTRL_JAL      = 3;
  localparam int unsigned CTRL_ALUIMM   = 4;
  localparam int unsigned CTRL_SHIFT    = 5;
  localparam int unsigned CTRL_ALUC_LSB = 6;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit plus control and data registers.
//   clk, resetn      rising-edge clock, synchronous active-low reset (clears everything)
//   load             capture load_ctrl/load_data and mark the entry valid
//   clear            invalidate the entry and zero its control; data is kept (wins over load)
//   valid/ctrl/data  registered entry contents
module pipe_slot #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 101
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      ctrl_q  <= load_ctrl;
      data_q  <= load_data;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register with valid/ready flow control, flush and optional skid entry.
//   clk, resetn          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready    upstream handshake; in_ctrl/in_data upstream payload
//   out_valid/out_ready  downstream handshake; out_ctrl/out_data payload (ctrl is 0 when empty)
//   flush                drop every held entry at the next edge
//   occupancy            number of held entries (0..1+SKID)
// SKID=1 makes in_ready a pure register output at the cost of a second entry.
module elastic_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = ID_EX_CTRL_W,
  parameter int unsigned DATA_W = ID_EX_DATA_W,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  logic              accept, issue;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              main_load, main_clear, skid_load, skid_clear;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] main_data_d;

  assign accept = in_valid & in_ready;
  assign issue  = main_valid & out_ready;

  always_comb begin
    main_load   = 1'b0;
    main_clear  = flush;
    skid_load   = 1'b0;
    skid_clear  = flush;
    main_ctrl_d = in_ctrl;
    main_data_d = in_data;
    if (!flush) begin
      if (skid_valid && issue) begin
        // Skid drains into main; in_ready was low so nothing new arrives.
        main_load   = 1'b1;
        main_ctrl_d = skid_ctrl;
        main_data_d = skid_data;
        skid_clear  = 1'b1;
      end else if (accept && (!main_valid || issue)) begin
        main_load = 1'b1;
      end else if (accept) begin
        // Main is stalled: park the new item (reachable only with SKID=1).
        skid_load = 1'b1;
      end else if (issue) begin
        main_clear = 1'b1;
      end
    end
  end

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk       (clk),
    .resetn    (resetn),
    .load      (main_load),
    .clear     (main_clear),
    .load_ctrl (main_ctrl_d),
    .load_data (main_data_d),
    .valid     (main_valid),
    .ctrl      (main_ctrl),
    .data      (main_data)
  );

  if (SKID != 0) begin : g_skid
    pipe_slot #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_skid (
      .clk       (clk),
      .resetn    (resetn),
      .load      (skid_load),
      .clear     (skid_clear),
      .load_ctrl (in_ctrl),
      .load_data (in_data),
      .valid     (skid_valid),
      .ctrl      (skid_ctrl),
      .data      (skid_data)
    );
    assign in_ready = ~skid_valid;
  end else begin : g_no_skid
    logic unused_skid;
    assign unused_skid = ^{skid_load, skid_clear};
    assign skid_valid  = 1'b0;
    assign skid_ctrl   = '0;
    assign skid_data   = '0;
    assign in_ready    = ~main_valid | out_ready;
  end

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed and random checks of elastic_pipe_reg with SKID=1 (u_dut) and SKID=0 (u_dut0).
module tb_elastic_pipe_reg;

  localparam int unsigned CW = 8;
  localparam int unsigned DW = 101;

  logic          clk = 1'b0;
  logic          resetn;
  // SKID=1 instance signals
  logic          in_valid, in_ready, out_valid, out_ready, flush;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
  // SKID=0 instance signals
  logic          in_valid0, in_ready0, out_valid0, out_ready0, flush0;
  logic [CW-1:0] in_ctrl0, out_ctrl0;
  logic [DW-1:0] in_data0, out_data0;
  logic [1:0]    occupancy0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  elastic_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy)
  );

  elastic_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_dut0 (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .in_ctrl   (in_ctrl0),
    .in_data   (in_data0),
    .out_valid (out_valid0),
    .out_ready (out_ready0),
    .out_ctrl  (out_ctrl0),
    .out_data  (out_data0),
    .flush     (flush0),
    .occupancy (occupancy0)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the random phase: each entry is {ctrl, data}.
  logic [CW+DW-1:0] sb[$];

  initial begin
    logic [127:0] r;
    logic         acc, iss;
    resetn = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'hFF; in_data = '1; out_ready = 1'b0; flush = 1'b0;
    in_valid0 = 1'b1; in_ctrl0 = 8'hFF; in_data0 = '1; out_ready0 = 1'b0; flush0 = 1'b0;

    // Reset with upstream pushing: nothing may be captured.
    repeat (2) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_data", out_data, 0);
    check("rst_occ", occupancy, 0);
    check("rst_out_valid0", out_valid0, 0);
    check("rst_occ0", occupancy0, 0);
    resetn = 1'b1; in_valid = 1'b0; in_valid0 = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_in_ready0", in_ready0, 1);
    check("rst_idle_occ", occupancy, 0);

    // Streaming, no back-pressure: one-cycle latency, occupancy stays 1.
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_ctrl = CW'(i); in_data = DW'(i * 3);
      tick();
      check("stream_ctrl", out_ctrl, i);
      check("stream_data", out_data, i * 3);
      check("stream_occ", occupancy, 1);
      check("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain_valid", out_valid, 0);
    check("stream_drain_ctrl", out_ctrl, 0);
    check("stream_drain_data_hold", out_data, 12);
    check("stream_drain_occ", occupancy, 0);

    // Stall into the skid entry, then drain.
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h11; in_data = DW'('hA);
    tick();
    in_ctrl = 8'h22; in_data = DW'('hB);
    tick();
    in_valid = 1'b0;
    check("skid_occ2", occupancy, 2);
    check("skid_in_ready", in_ready, 0);
    check("skid_hold_ctrl", out_ctrl, 8'h11);
    tick();
    check("stall_hold_ctrl", out_ctrl, 8'h11);
    check("stall_hold_data", out_data, 'hA);
    out_ready = 1'b1;
    tick();
    check("skid_drain_ctrl", out_ctrl, 8'h22);
    check("skid_drain_data", out_data, 'hB);
    check("skid_drain_occ1", occupancy, 1);
    check("skid_drain_in_ready", in_ready, 1);
    tick();
    check("skid_drain_occ0", occupancy, 0);
    check("skid_drain_valid", out_valid, 0);

    // Flush while full, with a simultaneous push of 8'h33.
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h44; tick();
    in_ctrl = 8'h55; tick();
    check("flush_pre_occ", occupancy, 2);
    in_ctrl = 8'h33; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_ctrl", out_ctrl, 0);
    check("flush_occ", occupancy, 0);
    out_ready = 1'b1;
    tick();
    check("flush_no_33_valid", out_valid, 0);
    check("flush_no_33_ctrl", out_ctrl, 0);

    // SKID=0: combinational in_ready, replace-on-issue.
    out_ready0 = 1'b0;
    in_valid0 = 1'b1; in_ctrl0 = 8'h66; in_data0 = DW'('h66);
    tick();
    in_valid0 = 1'b0;
    #1;
    check("s0_full_in_ready", in_ready0, 0);
    check("s0_full_ctrl", out_ctrl0, 8'h66);
    tick();
    check("s0_stall_ctrl", out_ctrl0, 8'h66);
    out_ready0 = 1'b1; in_valid0 = 1'b1; in_ctrl0 = 8'h77; in_data0 = DW'('h77);
    #1;
    check("s0_comb_in_ready", in_ready0, 1);
    tick();
    check("s0_replace_ctrl", out_ctrl0, 8'h77);
    check("s0_replace_data", out_data0, 'h77);
    check("s0_replace_occ", occupancy0, 1);
    in_valid0 = 1'b0;
    tick();
    check("s0_drain_occ", occupancy0, 0);
    check("s0_drain_ctrl", out_ctrl0, 0);

    // Random traffic on the SKID=1 instance against a queue model.
    resetn = 1'b0; tick(); resetn = 1'b1;
    sb.delete();
    for (int c = 0; c < 1000; c++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_valid  = ($urandom_range(99) < 60);
      out_ready = ($urandom_range(99) < 60);
      flush     = ($urandom_range(99) < 5);
      in_ctrl   = r[127:120];
      in_data   = r[100:0];
      #1;
      check("rnd_occ", occupancy, sb.size());
      check("rnd_in_ready", in_ready, sb.size() < 2);
      check("rnd_out_valid", out_valid, sb.size() > 0);
      if (sb.size() > 0) begin
        check("rnd_out_ctrl", out_ctrl, sb[0][CW+DW-1:DW]);
        check("rnd_out_data", out_data, sb[0][DW-1:0]);
      end else begin
        check("rnd_empty_ctrl_zero", out_ctrl, 0);
      end
      acc = in_valid && (sb.size() < 2);
      iss = out_ready && (sb.size() > 0);
      @(posedge clk);
      if (flush) begin
        sb.delete();
      end else begin
        if (iss) void'(sb.pop_front());
        if (acc) sb.push_back({in_ctrl, in_data});
      end
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
